// File: rtl/cp0_regs.sv
// MIPS coprocessor-0 register file: Count/Compare timer, Status/Cause/EPC/BadVAddr,
// MTC0/MFC0 access and exception commit from the exception-type encoder.
module cp0_regs #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic       tick;
    logic       exc_commit;
    logic       exc_eret;
    logic       exc_badaddr;
    logic [4:0] exc_code;
    logic       wr;
    logic       inc;

    always_comb begin
        exc_commit  = 1'b1;
        exc_badaddr = 1'b0;
        exc_code    = 5'h00;
        case (excepttype_i)
            32'h0000_0001: exc_code = 5'h00;
            32'h0000_0004: begin exc_code = 5'h04; exc_badaddr = 1'b1; end
            32'h0000_0005: begin exc_code = 5'h05; exc_badaddr = 1'b1; end
            32'h0000_0008: exc_code = 5'h08;
            32'h0000_0009: exc_code = 5'h09;
            32'h0000_000A: exc_code = 5'h0A;
            32'h0000_000C: exc_code = 5'h0C;
            default:       exc_commit = 1'b0;
        endcase
    end

    assign exc_eret = (excepttype_i == 32'h0000_000E);
    // A committing exception or ERET kills any MTC0 issued in the same cycle.
    assign wr  = we_i & ~(exc_commit | exc_eret);
    assign inc = (COUNT_DIV == 1) ? 1'b1 : tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick        <= 1'b0;
            count_o     <= 32'h0;
            compare_o   <= 32'h0;
            status_o    <= 32'h0040_0000;
            cause_o     <= 32'h0;
            epc_o       <= 32'h0;
            badvaddr_o  <= 32'h0;
            timer_int_o <= 1'b0;
        end else begin
            tick <= (COUNT_DIV == 1) ? 1'b0 : ~tick;

            if (wr && waddr_i == REG_COUNT)
                count_o <= data_i;
            else if (inc)
                count_o <= count_o + 32'd1;

            if (wr && waddr_i == REG_COMPARE) begin
                compare_o   <= data_i;
                timer_int_o <= 1'b0;
            end else if (count_o == compare_o && compare_o != 32'h0) begin
                timer_int_o <= 1'b1;
            end

            cause_o[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]};
            cause_o[30]    <= timer_int_o;

            if (wr && waddr_i == REG_STATUS) begin
                status_o[15:8] <= data_i[15:8];
                status_o[1:0]  <= data_i[1:0];
            end
            if (wr && waddr_i == REG_CAUSE)
                cause_o[9:8] <= data_i[9:8];
            if (wr && waddr_i == REG_EPC)
                epc_o <= data_i;

            // Nested exceptions keep the original EPC/BD so the outer handler can return.
            if (exc_commit) begin
                cause_o[6:2] <= exc_code;
                if (!status_o[1]) begin
                    epc_o       <= is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                     : current_inst_addr_i;
                    cause_o[31] <= is_in_delayslot_i;
                end
                status_o[1] <= 1'b1;
                if (exc_badaddr)
                    badvaddr_o <= bad_addr_i;
            end else if (exc_eret) begin
                status_o[1] <= 1'b0;
            end
        end
    end

    always_comb begin
        case (raddr_i)
            REG_BADVADDR: data_o = badvaddr_o;
            REG_COUNT:    data_o = count_o;
            REG_COMPARE:  data_o = compare_o;
            REG_STATUS:   data_o = status_o;
            REG_CAUSE:    data_o = cause_o;
            REG_EPC:      data_o = epc_o;
            default:      data_o = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: table-driven MTC0/MFC0 and exception vectors
// feeding a queue of expected outputs, plus hand-written timer and collision sequences.
module tb_cp0_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [4:0]  raddr_i = '0;
    logic [31:0] data_i = '0;
    logic [5:0]  int_i = '0;
    logic [31:0] excepttype_i = '0;
    logic [31:0] current_inst_addr_i = '0;
    logic        is_in_delayslot_i = 1'b0;
    logic [31:0] bad_addr_i = '0;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
    logic        timer_int_o;

    logic [31:0] d1_data, d1_count, d1_compare, d1_status, d1_cause, d1_epc, d1_badv;
    logic        d1_timer;

    int checks = 0;
    int errors = 0;
    int edges_rel = 0;

    cp0_regs #(.COUNT_DIV(2)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .int_i(int_i), .excepttype_i(excepttype_i),
        .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
        .bad_addr_i(bad_addr_i), .data_o(data_o), .count_o(count_o), .compare_o(compare_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
        .timer_int_o(timer_int_o)
    );

    cp0_regs #(.COUNT_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .we_i(1'b0), .waddr_i(5'd0), .raddr_i(5'd0),
        .data_i(32'h0), .int_i(6'h0), .excepttype_i(32'h0),
        .current_inst_addr_i(32'h0), .is_in_delayslot_i(1'b0),
        .bad_addr_i(32'h0), .data_o(d1_data), .count_o(d1_count), .compare_o(d1_compare),
        .status_o(d1_status), .cause_o(d1_cause), .epc_o(d1_epc), .badvaddr_o(d1_badv),
        .timer_int_o(d1_timer)
    );

    always #5 clk = ~clk;

    localparam int S_DATA = 0, S_COUNT = 1, S_COMPARE = 2, S_STATUS = 3, S_CAUSE = 4,
                   S_EPC = 5, S_BADV = 6, S_TIMER = 7, S_COUNT1 = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] mask;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];

    function automatic logic [31:0] out_sel(int sel);
        case (sel)
            S_DATA:    return data_o;
            S_COUNT:   return count_o;
            S_COMPARE: return compare_o;
            S_STATUS:  return status_o;
            S_CAUSE:   return cause_o;
            S_EPC:     return epc_o;
            S_BADV:    return badvaddr_o;
            S_TIMER:   return {31'h0, timer_int_o};
            default:   return d1_count;
        endcase
    endfunction

    task automatic expect_out(input string name, input int sel, input logic [31:0] mask,
                              input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.mask = mask;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    task automatic drain();
        chk_t c;
        logic [31:0] act;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            act = out_sel(c.sel) & c.mask;
            checks++;
            if (act !== (c.exp & c.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h (mask %h)", c.name, act,
                         c.exp & c.mask, c.mask);
            end
        end
    endtask

    task automatic step();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        if (!r) edges_rel++;
        drain();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1;
        waddr_i = a;
        data_i = d;
    endtask

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } wvec_t;

    typedef struct {
        logic [31:0] code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic [4:0]  excode;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] badv;
        logic        do_eret;
    } evec_t;

    wvec_t wt[10];
    evec_t et[5];

    initial begin
        wt[0] = '{5'd11, 32'hFFFF_0000, 5'd11, 32'hFFFF_0000};
        wt[1] = '{5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF03};
        wt[2] = '{5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300};
        wt[3] = '{5'd14, 32'hDEAD_BEEF, 5'd14, 32'hDEAD_BEEF};
        wt[4] = '{5'd8,  32'h0000_0055, 5'd8,  32'h0000_0000};
        wt[5] = '{5'd7,  32'h0000_0001, 5'd7,  32'h0000_0000};
        wt[6] = '{5'd12, 32'h0000_0000, 5'd12, 32'h0040_0000};
        wt[7] = '{5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};
        wt[8] = '{5'd11, 32'h0000_0000, 5'd11, 32'h0000_0000};
        wt[9] = '{5'd9,  32'h1234_5678, 5'd9,  32'h1234_5678};

        et[0] = '{32'h01, 32'h0000_0100, 1'b0, 32'h77,   5'h00, 32'h0000_0100, 1'b0, 32'h0,    1'b1};
        et[1] = '{32'h05, 32'h0000_0204, 1'b1, 32'hABCD, 5'h05, 32'h0000_0200, 1'b1, 32'hABCD, 1'b1};
        et[2] = '{32'h09, 32'h0000_0300, 1'b0, 32'h11,   5'h09, 32'h0000_0300, 1'b0, 32'hABCD, 1'b1};
        et[3] = '{32'h0A, 32'h0000_0404, 1'b1, 32'h22,   5'h0A, 32'h0000_0400, 1'b1, 32'hABCD, 1'b1};
        et[4] = '{32'h08, 32'hBFC0_0104, 1'b1, 32'h33,   5'h08, 32'hBFC0_0100, 1'b1, 32'hABCD, 1'b0};

        // reset
        step();
        step();
        expect_out("rst_status", S_STATUS, '1, 32'h0040_0000);
        expect_out("rst_count", S_COUNT, '1, 32'h0);
        expect_out("rst_compare", S_COMPARE, '1, 32'h0);
        expect_out("rst_cause", S_CAUSE, '1, 32'h0);
        expect_out("rst_epc", S_EPC, '1, 32'h0);
        expect_out("rst_badv", S_BADV, '1, 32'h0);
        expect_out("rst_timer", S_TIMER, '1, 32'h0);
        expect_out("rst_data", S_DATA, '1, 32'h0);
        drain();
        rst = 1'b0;
        expect_out("count_first", S_COUNT, '1, 32'h0);
        step();
        expect_out("count_second", S_COUNT, '1, 32'h1);
        expect_out("count_div1", S_COUNT1, '1, 32'd2);
        step();

        // MTC0 then MFC0 of each register
        for (int i = 0; i < 10; i++) begin
            mtc0(wt[i].waddr, wt[i].wdata);
            raddr_i = wt[i].raddr;
            expect_out($sformatf("wr_rd_%0d", i), S_DATA, '1, wt[i].exp);
            step();
        end
        we_i = 1'b0;

        // same-cycle write is not forwarded to the read port
        mtc0(5'd14, 32'hCAFE_F00D);
        raddr_i = 5'd14;
        #1;
        expect_out("no_forward", S_DATA, '1, 32'hDEAD_BEEF);
        drain();
        expect_out("epc_written", S_DATA, '1, 32'hCAFE_F00D);
        step();

        // Count wrap: exactly one increment in any two cycles
        mtc0(5'd9, 32'hFFFF_FFFF);
        expect_out("count_max", S_COUNT, '1, 32'hFFFF_FFFF);
        step();
        we_i = 1'b0;
        step();
        expect_out("count_wrap", S_COUNT, '1, 32'h0);
        step();

        // exceptions with EXL=0, each followed by ERET
        for (int i = 0; i < 5; i++) begin
            excepttype_i = et[i].code;
            current_inst_addr_i = et[i].pc;
            is_in_delayslot_i = et[i].ds;
            bad_addr_i = et[i].bad;
            expect_out($sformatf("exc%0d_code", i), S_CAUSE, 32'h7C, {25'h0, et[i].excode, 2'b00});
            expect_out($sformatf("exc%0d_epc", i), S_EPC, '1, et[i].epc);
            expect_out($sformatf("exc%0d_bd", i), S_CAUSE, 32'h8000_0000, {et[i].bd, 31'h0});
            expect_out($sformatf("exc%0d_exl", i), S_STATUS, 32'h2, 32'h2);
            expect_out($sformatf("exc%0d_badv", i), S_BADV, '1, et[i].badv);
            step();
            if (et[i].do_eret) begin
                excepttype_i = 32'h0E;
                expect_out($sformatf("eret%0d_exl", i), S_STATUS, 32'h2, 32'h0);
                expect_out($sformatf("eret%0d_code", i), S_CAUSE, 32'h7C, {25'h0, et[i].excode, 2'b00});
                step();
            end
        end

        // nested AdEL: EPC and BD kept, BadVAddr and ExcCode updated
        excepttype_i = 32'h04;
        current_inst_addr_i = 32'h0000_1000;
        is_in_delayslot_i = 1'b0;
        bad_addr_i = 32'h0000_0003;
        expect_out("adel_badv", S_BADV, '1, 32'h3);
        expect_out("adel_code", S_CAUSE, 32'h7C, 32'h10);
        expect_out("adel_epc", S_EPC, '1, 32'hBFC0_0100);
        expect_out("adel_bd", S_CAUSE, 32'h8000_0000, 32'h8000_0000);
        step();
        excepttype_i = 32'h0E;
        expect_out("eret_status", S_STATUS, '1, 32'h0040_0000);
        step();

        // collision: exception suppresses MTC0
        mtc0(5'd14, 32'h0000_1234);
        excepttype_i = 32'h0C;
        current_inst_addr_i = 32'h0000_0080;
        expect_out("coll_epc", S_EPC, '1, 32'h80);
        expect_out("coll_code", S_CAUSE, 32'h7C, 32'h30);
        expect_out("coll_exl", S_STATUS, 32'h2, 32'h2);
        step();
        we_i = 1'b0;
        excepttype_i = 32'h0E;
        expect_out("coll_eret_exl", S_STATUS, 32'h2, 32'h0);
        expect_out("coll_eret_epc", S_EPC, '1, 32'h80);
        step();

        // unrecognised code changes nothing
        excepttype_i = 32'h02;
        current_inst_addr_i = 32'h0000_0900;
        expect_out("inv_exl", S_STATUS, 32'h2, 32'h0);
        expect_out("inv_epc", S_EPC, '1, 32'h80);
        expect_out("inv_code", S_CAUSE, 32'h7C, 32'h30);
        step();
        excepttype_i = 32'h0;

        // ERET colliding with a Count write: write dropped, Count still ticks
        mtc0(5'd9, 32'h0);
        step();
        mtc0(5'd9, 32'h0BAD_0000);
        excepttype_i = 32'h0E;
        expect_out("coll_count", S_COUNT, 32'hFFFF_FFFE, 32'h0);
        step();
        we_i = 1'b0;
        excepttype_i = 32'h0;

        // timer interrupt
        mtc0(5'd9, 32'h0);
        step();
        mtc0(5'd11, 32'h5);
        step();
        we_i = 1'b0;
        begin
            logic found;
            found = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (count_o == 32'h5) begin
                    found = 1'b1;
                    break;
                end
                step();
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL timer_reach: count_o never reached 5, last %h", count_o);
            end
        end
        expect_out("timer_not_yet", S_TIMER, '1, 32'h0);
        drain();
        expect_out("timer_set", S_TIMER, '1, 32'h1);
        step();
        expect_out("timer_cause", S_CAUSE, 32'h4000_8000, 32'h4000_8000);
        expect_out("timer_sticky", S_TIMER, '1, 32'h1);
        step();
        mtc0(5'd11, 32'd100);
        expect_out("timer_clear", S_TIMER, '1, 32'h0);
        step();
        we_i = 1'b0;
        expect_out("timer_cause_clr", S_CAUSE, 32'h4000_8000, 32'h0);
        step();

        // Compare write beats a same-cycle match
        mtc0(5'd9, 32'd100);
        step();
        mtc0(5'd11, 32'd200);
        expect_out("timer_prio", S_TIMER, '1, 32'h0);
        step();
        we_i = 1'b0;

        // read path with hardware interrupts
        int_i = 6'b000001;
        raddr_i = 5'd13;
        expect_out("rd_ip2", S_DATA, 32'h0000_8400, 32'h0000_0400);
        step();
        int_i = 6'b100000;
        expect_out("rd_ip7", S_DATA, 32'h0000_8400, 32'h0000_8000);
        step();
        raddr_i = 5'd7;
        #1;
        expect_out("rd_unmapped", S_DATA, '1, 32'h0);
        drain();
        int_i = 6'b0;

        expect_out("count_div1_end", S_COUNT1, '1, edges_rel);
        drain();

        // reset wins over a same-cycle write and exception
        rst = 1'b1;
        mtc0(5'd14, 32'h5555_5555);
        excepttype_i = 32'h08;
        expect_out("midrst_status", S_STATUS, '1, 32'h0040_0000);
        expect_out("midrst_epc", S_EPC, '1, 32'h0);
        expect_out("midrst_count", S_COUNT, '1, 32'h0);
        expect_out("midrst_compare", S_COMPARE, '1, 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_regs.md
Name: cp0_regs

Overview:
- Coprocessor-0 register file for the MIPS core. Sits directly downstream of the exception-type encoder.
- Consumes its 32-bit exception code and commits the exception: updates EPC, Cause, Status and BadVAddr.
- Services MTC0/MFC0 and implements the Count/Compare timer.
- Feeds Status and Cause back to the encoder, and EPC to the PC-select logic.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV clocks (legal values 1 or 2).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- we_i  in  1  MTC0 write enable
- waddr_i  in  5  MTC0 destination register number
- raddr_i  in  5  MFC0 source register number
- data_i  in  32  MTC0 write data
- int_i  in  6  external hardware interrupt lines, level-sensitive
- excepttype_i  in  32  exception code from encoder (0 = none)
- current_inst_addr_i  in  32  PC of the excepting instruction
- is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot
- bad_addr_i  in  32  faulting address for AdEL/AdES
- data_o  out  32  MFC0 read data, combinational
- count_o  out  32  Count (reg 9)
- compare_o  out  32  Compare (reg 11)
- status_o  out  32  Status (reg 12)
- cause_o  out  32  Cause (reg 13)
- epc_o  out  32  EPC (reg 14)
- badvaddr_o  out  32  BadVAddr (reg 8)
- timer_int_o  out  1  timer interrupt pending

Behaviour:
- Reset values, all outputs: Status=32'h0040_0000 (BEV=1); every other register 0; timer_int_o=0; divider tick flop 0.
- Count:
  - COUNT_DIV=2: the tick flop toggles every cycle, and Count increments by 1 when tick=1.
  - COUNT_DIV=1: Count increments every cycle.
  - Count wraps 32'hFFFF_FFFF→0.
- Timer:
  - timer_int_o sets on the cycle after Count==Compare with Compare!=0. It stays set (sticky).
  - Only an MTC0 to Compare clears it; that write has priority over a same-cycle set.
- Cause, updated every cycle regardless of other events:
  - Cause[15:10] ← {int_i[5]|timer_int_o, int_i[4:0]}.
  - Cause[30] (TI) ← timer_int_o.
- MTC0 writable fields (write takes effect next cycle):
  - Count: full 32 bits. A write overrides the same-cycle increment.
  - Compare: full 32 bits.
  - Status: [15:8] IM, [1] EXL, [0] IE.
  - Cause: [9:8] only.
  - EPC: full 32 bits.
  - BadVAddr and all other bits are read-only.
- MFC0 read:
  - data_o is combinational on raddr_i: 8→BadVAddr, 9→Count, 11→Compare, 12→Status, 13→Cause, 14→EPC, others→0.
  - Same-cycle write is not forwarded; data_o returns the pre-write value.
- Exception commit, for excepttype_i ∈ {01,04,05,08,09,0A,0C}:
  - ExcCode Cause[6:2] ← 00, 04, 05, 08, 09, 0A, 0C respectively.
  - If Status.EXL==0: EPC ← is_in_delayslot_i ? current_inst_addr_i−4 : current_inst_addr_i; Cause[31] BD ← is_in_delayslot_i.
  - If EXL was already 1: EPC and BD are unchanged.
  - Status.EXL ← 1 in both cases.
  - Codes 04 and 05 additionally set BadVAddr ← bad_addr_i.
- ERET: excepttype_i==0E clears Status.EXL only.
- Any other non-zero code: no state change.
- Exception collision: a nonzero valid excepttype_i in the same cycle as we_i suppresses the MTC0 write entirely.
  - Count still ticks.
  - Cause IP and TI still update.
- Reset mid-operation: rst wins over every write, exception and tick that cycle.

Test Plan:
- Reset:
  - Stimulus: hold rst 2 cycles, then release with all inputs 0.
  - Required: status_o=32'h0040_0000, all others 0; count_o=1 after 2 clocks (COUNT_DIV=2).
- Timer interrupt:
  - Stimulus: MTC0 Compare=5 and Count=0, then wait.
  - Required: timer_int_o=1 one cycle after count_o==5; cause_o[30]=1 and cause_o[15]=1.
  - Then MTC0 Compare=100; timer_int_o=0 next cycle.
- Syscall in delay slot:
  - Stimulus: excepttype_i=8, pc=32'hBFC0_0104, delayslot=1, EXL=0.
  - Required: epc_o=32'hBFC0_0100, cause_o[31]=1, cause_o[6:2]=8, status_o[1]=1.
- AdEL with nested EXL:
  - Stimulus: excepttype_i=4, bad_addr_i=32'h0000_0003 while EXL=1.
  - Required: badvaddr_o=3, ExcCode=4, epc_o unchanged.
- Collision and ERET:
  - Stimulus: we_i=1, waddr_i=14, data_i=32'h1234 together with excepttype_i=0C, pc=32'h80.
  - Required: epc_o=32'h80.
  - Next: excepttype_i=0E; status_o[1]=0.
- Read path:
  - Stimulus: raddr_i=13 with int_i=6'b000001 held.
  - Required: data_o[10]=1 one cycle later.
  - Stimulus: raddr_i=7.
  - Required: data_o=0.
